// File: rtl/stream_scb_pkg.sv
// Shared types and constants for the stream_scb latency-tolerant scoreboard.
package stream_scb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scb_state_e;

  typedef logic [31:0] scb_cnt_t;

  localparam scb_cnt_t SCB_CNT_MAX = 32'hFFFF_FFFF;

  function automatic scb_cnt_t scb_sat_inc(input scb_cnt_t c);
    return (c == SCB_CNT_MAX) ? c : c + 32'd1;
  endfunction

endpackage

// File: rtl/stream_scb_ref_fifo.sv
// Circular reference FIFO for stream_scb; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module scb_ref_fifo #(
  parameter int DATA_W = 48,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       aresetn,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_en;
  logic              rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  always_comb begin
    rd_en = pop && !empty;
    wr_en = push && (!full || rd_en);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stream_scb.sv
// Latency-tolerant in-order scoreboard: FSM, compare, watchdog and counters.
// Optional feature macro: SCB_TRACE_EN (event trace via $display).
module stream_scb
  import stream_scb_pkg::*;
#(
  parameter int DATA_W  = 48,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       aresetn,
  input  logic                       scoreboard_en,
  input  logic                       scoreboard_reset,
  input  logic                       drain_req,
  input  logic                       ref_valid,
  input  logic signed [DATA_W-1:0]   ref_data,
  input  logic                       duv_valid,
  input  logic signed [DATA_W-1:0]   duv_data,
  output scb_cnt_t                   test_count,
  output scb_cnt_t                   error_count,
  output logic [$clog2(DEPTH):0]     pending,
  output logic                       timeout,
  output logic                       done
);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  scb_state_e        state;
  scb_state_e        state_nxt;
  logic [WD_W-1:0]   wd_cnt;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] cmp_ref;
  logic              fifo_full;
  logic              fifo_empty;
  logic              run;
  logic              cmp_on;
  logic              bypass;
  logic              pop;
  logic              push;
  logic              compare;
  logic              mismatch;
  logic              unexpected;
  logic              overflow;
  logic              wd_run;
  logic              wd_fire;
  logic              err_evt;

  scb_ref_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .aresetn (aresetn),
    .clr     (scoreboard_reset),
    .push    (push),
    .pop     (pop),
    .wdata   (ref_data),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (pending)
  );

  // Bypass only applies while refs are accepted; in DRAIN an empty-queue output is unexpected.
  always_comb begin
    run        = (state == RUN);
    cmp_on     = run || (state == DRAIN);
    bypass     = run && duv_valid && ref_valid && fifo_empty;
    pop        = cmp_on && duv_valid && !fifo_empty;
    push       = run && ref_valid && !bypass;
    compare    = pop || bypass;
    cmp_ref    = bypass ? ref_data : head;
    mismatch   = compare && (cmp_ref !== duv_data);
    unexpected = cmp_on && duv_valid && fifo_empty && !bypass;
    overflow   = push && fifo_full && !pop;
    wd_run     = cmp_on && !timeout && !fifo_empty && !duv_valid;
    wd_fire    = wd_run && (wd_cnt == WD_W'(TIMEOUT - 1));
    err_evt    = mismatch || unexpected || overflow || wd_fire;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (scoreboard_en) state_nxt = RUN;
      RUN:     if (!scoreboard_en) state_nxt = IDLE;
               else if (drain_req) state_nxt = DRAIN;
      DRAIN:   if ((pending == '0) || timeout) state_nxt = DONE;
      default: state_nxt = DONE;
    endcase
  end

  assign done = (state == DONE);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      test_count  <= '0;
      error_count <= '0;
      timeout     <= 1'b0;
      wd_cnt      <= '0;
    end else if (scoreboard_reset) begin
      state       <= IDLE;
      test_count  <= '0;
      error_count <= '0;
      timeout     <= 1'b0;
      wd_cnt      <= '0;
    end else begin
      state <= state_nxt;
      if (compare) test_count  <= scb_sat_inc(test_count);
      if (err_evt) error_count <= scb_sat_inc(error_count);
      if (wd_fire) timeout     <= 1'b1;
      // Once timeout is set the watchdog value freezes until reset.
      if (!timeout) begin
        if (fifo_empty || duv_valid) wd_cnt <= '0;
        else if (wd_run)             wd_cnt <= wd_cnt + WD_W'(1);
      end
    end
  end

`ifdef SCB_TRACE_EN
  always_ff @(posedge clk) begin
    if (aresetn && !scoreboard_reset) begin
      if (mismatch)
        $display("%0t stream_scb mismatch test=%0d ref=%0h duv=%0h",
                 $time, test_count, cmp_ref, duv_data);
      if (unexpected)
        $display("%0t stream_scb unexpected duv=%0h", $time, duv_data);
      if (overflow)
        $display("%0t stream_scb overflow ref=%0h", $time, ref_data);
      if (wd_fire)
        $display("%0t stream_scb timeout pending=%0d", $time, pending);
    end
  end
`else
  // Silent build: event strobes feed only the counters.
`endif

endmodule

// File: tb/tb_stream_scb.sv
// Directed bench for stream_scb: main instance (TIMEOUT 1024) plus a watchdog instance (TIMEOUT 8).
module tb_stream_scb;
  localparam int DATA_W = 48;
  localparam int DEPTH  = 16;

  logic                     clk = 1'b0;
  logic                     aresetn;
  logic                     scoreboard_en;
  logic                     scoreboard_reset;
  logic                     drain_req;
  logic                     ref_valid;
  logic signed [DATA_W-1:0] ref_data;
  logic                     duv_valid;
  logic signed [DATA_W-1:0] duv_data;

  logic [31:0] a_tests, a_errs, b_tests, b_errs;
  logic [4:0]  a_pend, b_pend;
  logic        a_to, a_done, b_to, b_done;

  int total = 0;
  int bad   = 0;

  logic signed [DATA_W-1:0] exp_q [$];
  int m_tests;
  int pend_max;

  always #5 clk = ~clk;

  stream_scb #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(1024)) u_a (
    .clk(clk), .aresetn(aresetn), .scoreboard_en(scoreboard_en),
    .scoreboard_reset(scoreboard_reset), .drain_req(drain_req),
    .ref_valid(ref_valid), .ref_data(ref_data),
    .duv_valid(duv_valid), .duv_data(duv_data),
    .test_count(a_tests), .error_count(a_errs), .pending(a_pend),
    .timeout(a_to), .done(a_done)
  );

  stream_scb #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(8)) u_b (
    .clk(clk), .aresetn(aresetn), .scoreboard_en(scoreboard_en),
    .scoreboard_reset(scoreboard_reset), .drain_req(drain_req),
    .ref_valid(ref_valid), .ref_data(ref_data),
    .duv_valid(duv_valid), .duv_data(duv_data),
    .test_count(b_tests), .error_count(b_errs), .pending(b_pend),
    .timeout(b_to), .done(b_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ref_valid = 1'b0;
    duv_valid = 1'b0;
    drain_req = 1'b0;
  endtask

  task automatic sreset_and_run();
    idle_inputs();
    scoreboard_reset = 1'b1;
    step();
    scoreboard_reset = 1'b0;
    scoreboard_en    = 1'b1;
    step();
  endtask

  initial begin
    aresetn = 1'b0; scoreboard_en = 1'b0; scoreboard_reset = 1'b0;
    drain_req = 1'b0; ref_valid = 1'b0; ref_data = '0;
    duv_valid = 1'b0; duv_data = '0;
    step(); step();
    check("rst_tests", a_tests, 0);
    check("rst_errs",  a_errs,  0);
    check("rst_pend",  a_pend,  0);
    check("rst_to",    a_to,    0);
    check("rst_done",  a_done,  0);
    aresetn = 1'b1;
    step();

    // T1: latency-3 echo through a reference model queue
    scoreboard_en = 1'b1;
    step();
    m_tests  = 0;
    pend_max = 0;
    for (int c = 0; c < 103; c++) begin
      ref_valid = (c < 100);
      if (c < 100) begin
        ref_data = DATA_W'({$urandom(), $urandom()});
        exp_q.push_back(ref_data);
      end
      duv_valid = (c >= 3);
      if (c >= 3) begin
        duv_data = exp_q.pop_front();
        m_tests++;
      end
      step();
      if (int'(a_pend) > pend_max) pend_max = int'(a_pend);
    end
    idle_inputs();
    step();
    check("t1_tests",    a_tests,  64'(m_tests));
    check("t1_tests100", a_tests,  100);
    check("t1_errs",     a_errs,   0);
    check("t1_pend_max", pend_max, 3);
    check("t1_pend_end", a_pend,   0);

    // T2: signed mismatch, then X on the DUV side
    sreset_and_run();
    ref_valid = 1'b1; ref_data = -48'sd5; step();
    ref_valid = 1'b0; duv_valid = 1'b1; duv_data = 48'sd5; step();
    duv_valid = 1'b0; step();
    check("t2_errs",  a_errs,  1);
    check("t2_tests", a_tests, 1);
    ref_valid = 1'b1; ref_data = -48'sd5; step();
    ref_valid = 1'b0; duv_valid = 1'b1; duv_data = 'x; step();
    duv_valid = 1'b0; step();
    check("t2_errs_x",  a_errs,  2);
    check("t2_tests_x", a_tests, 2);

    // T3: overflow and push+pop while full
    sreset_and_run();
    for (int i = 0; i < 17; i++) begin
      ref_valid = 1'b1; ref_data = 48'(i);
      step();
    end
    ref_valid = 1'b0; step();
    check("t3_pend_full", a_pend, 16);
    check("t3_errs_ovf",  a_errs, 1);
    ref_valid = 1'b1; ref_data = 48'd99; duv_valid = 1'b1; duv_data = 48'd0;
    step();
    idle_inputs(); step();
    check("t3_pend_pp",  a_pend,  16);
    check("t3_errs_pp",  a_errs,  1);
    check("t3_tests_pp", a_tests, 1);

    // T4: unexpected output then empty bypass
    sreset_and_run();
    duv_valid = 1'b1; duv_data = 48'd7; step();
    duv_valid = 1'b0; step();
    check("t4_unexp_errs",  a_errs,  1);
    check("t4_unexp_tests", a_tests, 0);
    ref_valid = 1'b1; ref_data = 48'h1234; duv_valid = 1'b1; duv_data = 48'h1234;
    step();
    idle_inputs(); step();
    check("t4_byp_tests", a_tests, 1);
    check("t4_byp_pend",  a_pend,  0);
    check("t4_byp_errs",  a_errs,  1);

    // T5: watchdog on the TIMEOUT=8 instance
    sreset_and_run();
    ref_valid = 1'b1; ref_data = 48'd42; step();
    ref_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("t5_to_early", b_to,   0);
    check("t5_err_early", b_errs, 0);
    step();
    check("t5_to",   b_to,   1);
    check("t5_errs", b_errs, 1);
    step(); step();
    check("t5_errs_once", b_errs, 1);
    drain_req = 1'b1; step();
    check("t5_not_done_yet", b_done, 0);
    step();
    check("t5_done", b_done, 1);
    drain_req = 1'b0; scoreboard_en = 1'b0; step();
    check("t5_done_hold", b_done, 1);
    check("t5_a_not_done", a_done, 0);

    // T6: asynchronous reset mid-RUN, then synchronous reset with a push
    sreset_and_run();
    for (int i = 0; i < 5; i++) begin
      ref_valid = 1'b1; ref_data = 48'(i + 10);
      step();
    end
    ref_valid = 1'b0;
    check("t6_pend5", a_pend, 5);
    #2 aresetn = 1'b0;
    #1;
    check("t6_ar_pend",  a_pend,  0);
    check("t6_ar_tests", a_tests, 0);
    check("t6_ar_errs",  a_errs,  0);
    check("t6_ar_done",  b_done,  0);
    check("t6_ar_to",    b_to,    0);
    scoreboard_en = 1'b0;
    step();
    aresetn = 1'b1;
    ref_valid = 1'b1; ref_data = 48'd1; step();
    ref_valid = 1'b0; step();
    check("t6_idle_push_ignored", a_pend, 0);
    scoreboard_en = 1'b1; step();
    for (int i = 0; i < 3; i++) begin
      ref_valid = 1'b1; ref_data = 48'(i);
      step();
    end
    check("t6_pend3", a_pend, 3);
    scoreboard_reset = 1'b1; ref_valid = 1'b1; ref_data = 48'd77;
    step();
    scoreboard_reset = 1'b0; ref_valid = 1'b0;
    check("t6_sr_pend",  a_pend,  0);
    check("t6_sr_tests", a_tests, 0);
    check("t6_sr_errs",  a_errs,  0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
